// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy bit and producer tag for rename tracking.
// Optional macro REGFILE_BYPASS_EN adds same-cycle writeback-to-read forwarding.
module regfile_rename #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int NREAD   = 2,
  localparam int REG_W  = $clog2(REG_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_en,
  input  logic [TAG_W-1:0]          wb_tag,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      ren_en,
  input  logic [REG_W-1:0]          ren_name,
  input  logic [TAG_W-1:0]          ren_tag,
  input  logic                      flush,
  input  logic [NREAD*REG_W-1:0]    rd_name,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD*TAG_W-1:0]    rd_tag,
  output logic [NREAD-1:0]          rd_busy
);

  logic [DATA_W-1:0] data_q [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] wb_hit;

  // Every busy register waiting on the broadcast tag captures the result (stale duplicates included).
  always_comb begin
    wb_hit = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      wb_hit[r] = wb_en && busy_q[r] && (tag_q[r] == wb_tag);
    end
  end

  // Entry 0 is only ever written by reset, so it stays hard-wired to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int r = 0; r < REG_NUM; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (wb_hit[r]) data_q[r] <= wb_data;
        if (flush) begin
          busy_q[r] <= 1'b0;
        end else if (ren_en && (ren_name == REG_W'(r))) begin
          busy_q[r] <= 1'b1;
          tag_q[r]  <= ren_tag;
        end else if (wb_hit[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Reads see pre-update state, so a rename in the same cycle does not affect its own sources.
  always_comb begin
    rd_data = '0;
    rd_tag  = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = data_q[rd_name[i*REG_W +: REG_W]];
      rd_tag[i*TAG_W +: TAG_W]    = tag_q[rd_name[i*REG_W +: REG_W]];
      rd_busy[i]                  = busy_q[rd_name[i*REG_W +: REG_W]];
`ifdef REGFILE_BYPASS_EN
      if (wb_hit[rd_name[i*REG_W +: REG_W]]) begin
        rd_data[i*DATA_W +: DATA_W] = wb_data;
        rd_busy[i]                  = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed testbench for regfile_rename; expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_rename;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [3:0]  wb_tag;
  logic [31:0] wb_data;
  logic        ren_en;
  logic [4:0]  ren_name;
  logic [3:0]  ren_tag;
  logic        flush;
  logic [9:0]  rd_name;
  logic [63:0] rd_data;
  logic [7:0]  rd_tag;
  logic [1:0]  rd_busy;

  int errors = 0;
  int checks = 0;

  regfile_rename dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .ren_en(ren_en), .ren_name(ren_name), .ren_tag(ren_tag),
    .flush(flush), .rd_name(rd_name),
    .rd_data(rd_data), .rd_tag(rd_tag), .rd_busy(rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic rename(input logic [4:0] r, input logic [3:0] t);
    ren_en = 1'b1; ren_name = r; ren_tag = t;
    step();
    ren_en = 1'b0;
  endtask

  task automatic writeback(input logic [3:0] t, input logic [31:0] d);
    wb_en = 1'b1; wb_tag = t; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_tag = '0; wb_data = '0;
    ren_en = 1'b0; ren_name = '0; ren_tag = '0; flush = 1'b0; rd_name = '0;
    step();
    step();
    rst = 1'b0;

    // reset state
    rd_name = {5'd31, 5'd5};
    #1;
    check("reset_data0", rd_data[31:0], 32'h0);
    check("reset_data1", rd_data[63:32], 32'h0);
    check("reset_busy", {30'b0, rd_busy}, 32'h0);
    check("reset_tag", {24'b0, rd_tag}, 32'h0);

    // rename then writeback
    rename(5'd3, 4'd7);
    rd_name = {5'd0, 5'd3};
    #1;
    check("x3_busy", {31'b0, rd_busy[0]}, 32'h1);
    check("x3_tag", {28'b0, rd_tag[3:0]}, 32'h7);
    writeback(4'd7, 32'hDEADBEEF);
    check("x3_data", rd_data[31:0], 32'hDEADBEEF);
    check("x3_idle", {31'b0, rd_busy[0]}, 32'h0);

    // bypass case on port 1
    rename(5'd4, 4'd2);
    rd_name = {5'd4, 5'd0};
    wb_en = 1'b1; wb_tag = 4'd2; wb_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", rd_data[63:32], 32'h55);
    check("byp_busy", {31'b0, rd_busy[1]}, 32'h0);
`else
    check("nobyp_busy", {31'b0, rd_busy[1]}, 32'h1);
    check("nobyp_tag", {28'b0, rd_tag[7:4]}, 32'h2);
`endif
    step();
    wb_en = 1'b0;
    #1;
    check("x4_data", rd_data[63:32], 32'h55);
    check("x4_idle", {31'b0, rd_busy[1]}, 32'h0);

    // x6 = 0x10, then same-cycle rename and read
    rename(5'd6, 4'd5);
    writeback(4'd5, 32'h10);
    rd_name = {5'd0, 5'd6};
    ren_en = 1'b1; ren_name = 5'd6; ren_tag = 4'd9;
    #1;
    check("x6_pre_data", rd_data[31:0], 32'h10);
    check("x6_pre_busy", {31'b0, rd_busy[0]}, 32'h0);
    step();
    ren_en = 1'b0;
    #1;
    check("x6_busy", {31'b0, rd_busy[0]}, 32'h1);
    check("x6_tag9", {28'b0, rd_tag[3:0]}, 32'h9);
    rename(5'd6, 4'd10);
    writeback(4'd9, 32'h99);
    check("x6_still_busy", {31'b0, rd_busy[0]}, 32'h1);
    check("x6_tag10", {28'b0, rd_tag[3:0]}, 32'hA);
    check("x6_data_kept", rd_data[31:0], 32'h10);

    // stale tag reuse: both consumers update
    rename(5'd7, 4'd1);
    rename(5'd8, 4'd1);
    writeback(4'd1, 32'hAA);
    rd_name = {5'd8, 5'd7};
    #1;
    check("x7_data", rd_data[31:0], 32'hAA);
    check("x8_data", rd_data[63:32], 32'hAA);
    check("x7_x8_busy", {30'b0, rd_busy}, 32'h0);

    // flush beats a same-cycle rename
    rename(5'd9, 4'd3);
    flush = 1'b1;
    rename(5'd10, 4'd4);
    flush = 1'b0;
    rd_name = {5'd10, 5'd9};
    #1;
    check("flush_busy", {30'b0, rd_busy}, 32'h0);

    // x0 ignores rename and writeback
    rename(5'd0, 4'd5);
    writeback(4'd5, 32'hFFFFFFFF);
    rd_name = {5'd0, 5'd0};
    #1;
    check("x0_data", rd_data[31:0], 32'h0);
    check("x0_busy", {30'b0, rd_busy}, 32'h0);
    check("x0_tag", {24'b0, rd_tag}, 32'h0);

    // reset discards pending tags
    rename(5'd11, 4'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    writeback(4'd6, 32'h77);
    rd_name = {5'd3, 5'd11};
    #1;
    check("rst_x11_data", rd_data[31:0], 32'h0);
    check("rst_x11_busy", {31'b0, rd_busy[0]}, 32'h0);
    check("rst_x3_data", rd_data[63:32], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
